// File: rtl/chunked_add_sub_if.sv
// Request/result bundle for the chunked adder/subtractor.
// The master side launches operations; the slave side reports results and flags.
interface chunked_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SnA;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] Y;
    logic             CO;
    logic             OV;
    logic             ZERO;

    modport master (
        output START, SnA, A, B,
        input  BUSY, DONE, Y, CO, OV, ZERO
    );

    modport slave (
        input  START, SnA, A, B,
        output BUSY, DONE, Y, CO, OV, ZERO
    );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a registered carry.
// Y and the flags update only on the completion edge, so partial sums never leak out.
module chunked_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           CLK,
    input  logic           RST,
    chunked_add_sub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   sum;
    logic             cin_msb;
    logic [WIDTH-1:0] acc_wr;
    logic             last;

    always_comb begin
        a_c    = '0;
        b_c    = '0;
        acc_wr = acc_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_c = a_q[i*CHUNK +: CHUNK];
                b_c = b_q[i*CHUNK +: CHUNK];
            end
        end
        sum     = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
        // top bit of the last chunk is bit WIDTH-1; recover its carry-in
        cin_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum[CHUNK-1];
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                acc_wr[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
        last = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.B ^ {WIDTH{bus.SnA}};
                    carry_d = bus.SnA;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_wr;
                carry_d = sum[CHUNK];
                if (last) begin
                    y_d     = acc_wr;
                    co_d    = sum[CHUNK];
                    ov_d    = cin_msb ^ sum[CHUNK];
                    zero_d  = (acc_wr == '0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.BUSY = (state_q == S_RUN);
    assign bus.DONE = (state_q == S_DONE);
    assign bus.Y    = y_q;
    assign bus.CO   = co_q;
    assign bus.OV   = ov_q;
    assign bus.ZERO = zero_q;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Scoreboard bench: stimulus queues expected results, negedge monitors pop on DONE.
// Covers the 32/8 default plus WIDTH=16 with CHUNK=16, 4 and 1.
module tb_chunked_add_sub;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_add_sub_if #(.WIDTH(32)) m ();
    chunked_add_sub_if #(.WIDTH(16)) sa ();
    chunked_add_sub_if #(.WIDTH(16)) sb ();
    chunked_add_sub_if #(.WIDTH(16)) sc ();

    chunked_add_sub #(.WIDTH(32), .CHUNK(8))  u_m  (.CLK(clk), .RST(rst_n), .bus(m.slave));
    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_sa (.CLK(clk), .RST(rst_n), .bus(sa.slave));
    chunked_add_sub #(.WIDTH(16), .CHUNK(4))  u_sb (.CLK(clk), .RST(rst_n), .bus(sb.slave));
    chunked_add_sub #(.WIDTH(16), .CHUNK(1))  u_sc (.CLK(clk), .RST(rst_n), .bus(sc.slave));

    typedef struct {
        logic [31:0] y;
        logic        co;
        logic        ov;
        logic        z;
        int          t0;
        int          lat;
    } exp_t;

    exp_t qm[$];
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic cmp(string nm, exp_t e, logic [31:0] y, logic co, logic ov,
                       logic z, logic busy, int busy_n);
        chk({nm, " Y"}, y, e.y);
        chk({nm, " CO"}, {31'd0, co}, {31'd0, e.co});
        chk({nm, " OV"}, {31'd0, ov}, {31'd0, e.ov});
        chk({nm, " ZERO"}, {31'd0, z}, {31'd0, e.z});
        chk({nm, " latency"}, cyc - e.t0, e.lat);
        chk({nm, " busy cycles"}, busy_n, e.lat - 1);
        chk({nm, " BUSY with DONE"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic unexpected(string nm);
        checks++;
        errors++;
        $display("FAIL %s unexpected DONE got=1 expected=0", nm);
    endtask

    int bm, ba, bb, bc;

    always @(negedge clk) begin : mon_m
        exp_t e;
        if (!rst_n) bm = 0;
        else begin
            if (m.BUSY) bm++;
            if (m.DONE) begin
                if (qm.size() == 0) unexpected("main");
                else begin
                    e = qm.pop_front();
                    cmp("main", e, m.Y, m.CO, m.OV, m.ZERO, m.BUSY, bm);
                end
                bm = 0;
            end
        end
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_n) ba = 0;
        else begin
            if (sa.BUSY) ba++;
            if (sa.DONE) begin
                if (qa.size() == 0) unexpected("w16c16");
                else begin
                    e = qa.pop_front();
                    cmp("w16c16", e, {16'd0, sa.Y}, sa.CO, sa.OV, sa.ZERO, sa.BUSY, ba);
                end
                ba = 0;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_n) bb = 0;
        else begin
            if (sb.BUSY) bb++;
            if (sb.DONE) begin
                if (qb.size() == 0) unexpected("w16c4");
                else begin
                    e = qb.pop_front();
                    cmp("w16c4", e, {16'd0, sb.Y}, sb.CO, sb.OV, sb.ZERO, sb.BUSY, bb);
                end
                bb = 0;
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (!rst_n) bc = 0;
        else begin
            if (sc.BUSY) bc++;
            if (sc.DONE) begin
                if (qc.size() == 0) unexpected("w16c1");
                else begin
                    e = qc.pop_front();
                    cmp("w16c1", e, {16'd0, sc.Y}, sc.CO, sc.OV, sc.ZERO, sc.BUSY, bc);
                end
                bc = 0;
            end
        end
    end

    function automatic exp_t mk(logic [31:0] y, logic co, logic ov, int lat);
        exp_t e;
        e.y   = y;
        e.co  = co;
        e.ov  = ov;
        e.z   = (y == 32'd0);
        e.t0  = cyc;
        e.lat = lat;
        return e;
    endfunction

    task automatic drive_m(logic [31:0] a, logic [31:0] b, logic s, logic st);
        m.A     = a;
        m.B     = b;
        m.SnA   = s;
        m.START = st;
    endtask

    task automatic op(logic [31:0] a, logic [31:0] b, logic s,
                      logic [31:0] ey, logic eco, logic eov);
        @(negedge clk);
        drive_m(a, b, s, 1'b1);
        qm.push_back(mk(ey, eco, eov, 5));
        @(negedge clk);
        m.START = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic sweep(logic [15:0] a, logic [15:0] b, logic s);
        logic [16:0] r;
        logic [15:0] y;
        logic        ov;
        r  = {1'b0, a} + {1'b0, (s ? ~b : b)} + {16'd0, s};
        y  = r[15:0];
        ov = s ? ((a[15] != b[15]) && (y[15] != a[15]))
               : ((a[15] == b[15]) && (y[15] != a[15]));
        @(negedge clk);
        sa.A = a; sa.B = b; sa.SnA = s; sa.START = 1'b1;
        sb.A = a; sb.B = b; sb.SnA = s; sb.START = 1'b1;
        sc.A = a; sc.B = b; sc.SnA = s; sc.START = 1'b1;
        qa.push_back(mk({16'd0, y}, r[16], ov, 2));
        qb.push_back(mk({16'd0, y}, r[16], ov, 5));
        qc.push_back(mk({16'd0, y}, r[16], ov, 17));
        @(negedge clk);
        sa.START = 1'b0;
        sb.START = 1'b0;
        sc.START = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic chk_reset_outs(string nm);
        chk({nm, " Y"}, m.Y, 32'd0);
        chk({nm, " CO"}, {31'd0, m.CO}, 32'd0);
        chk({nm, " OV"}, {31'd0, m.OV}, 32'd0);
        chk({nm, " ZERO"}, {31'd0, m.ZERO}, 32'd1);
        chk({nm, " BUSY"}, {31'd0, m.BUSY}, 32'd0);
        chk({nm, " DONE"}, {31'd0, m.DONE}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } vec16_t;

    vec16_t sv[6];

    initial begin
        rst_n = 1'b0;
        drive_m(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b1);
        sa.START = 1'b1; sa.A = 16'h1; sa.B = 16'h1; sa.SnA = 1'b0;
        sb.START = 1'b0; sb.A = 16'h0; sb.B = 16'h0; sb.SnA = 1'b0;
        sc.START = 1'b0; sc.A = 16'h0; sc.B = 16'h0; sc.SnA = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        m.START  = 1'b0;
        sa.START = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);

        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op(32'd5, 32'd5, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        op(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // START during RUN with other operands must be ignored
        @(negedge clk);
        drive_m(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        qm.push_back(mk(32'h2345_6789, 1'b0, 1'b0, 5));
        @(negedge clk);
        m.START = 1'b0;
        @(negedge clk);
        drive_m(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        @(negedge clk);
        m.START = 1'b0;
        repeat (8) @(negedge clk);

        // back-to-back: START held through the DONE cycle
        @(negedge clk);
        drive_m(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        qm.push_back(mk(32'h7FFF_FFFF, 1'b1, 1'b1, 5));
        @(negedge clk);
        drive_m(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !m.DONE; i++) @(negedge clk);
        qm.push_back(mk(32'h8000_0000, 1'b0, 1'b1, 5));
        @(negedge clk);
        m.START = 1'b0;
        repeat (8) @(negedge clk);

        // reset in the second RUN cycle aborts with no DONE
        @(negedge clk);
        drive_m(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        @(negedge clk);
        m.START = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("abort");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        sv[0] = '{16'h7FFF, 16'h0001, 1'b0};
        sv[1] = '{16'h8000, 16'h0001, 1'b1};
        sv[2] = '{16'h1234, 16'h1234, 1'b1};
        sv[3] = '{16'hFFFF, 16'hFFFF, 1'b0};
        sv[4] = '{16'h00F0, 16'h0F10, 1'b0};
        sv[5] = '{16'h0003, 16'hA5A5, 1'b1};
        foreach (sv[i]) sweep(sv[i].a, sv[i].b, sv[i].s);

        chk("main pending", qm.size(), 0);
        chk("w16c16 pending", qa.size(), 0);
        chk("w16c4 pending", qb.size(), 0);
        chk("w16c1 pending", qc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
